// File: rtl/gic_reg_slave.sv
// -----------------------------------------------------------------------------
// gic_reg_slave
//
// Register-bus responder for the generic interrupt controller. It decodes
// word accesses on a simple reg bus into the controller register file,
// captures rising edges of the interrupt sources into a pending register,
// arbitrates pending+enabled sources by priority and drives a registered
// interrupt request plus a read-to-claim register.
//
// Register map (byte addresses, addr[1:0] ignored):
//   0x00 CTRL     bit0 global enable, bit1 LOCK (only with GIC_REG_LOCK_EN)
//   0x04 ENABLE   per-IRQ enable
//   0x08 PENDING  read pending, write-1-to-clear
//   0x0C SETPEND  write-1-to-set pending, reads 0
//   0x10 CLAIM    read {valid, 26'b0, id[4:0]} and clear the winner
//   0x20..0x2C    PRIO0..PRIO3, eight 4-bit fields per word
//
// Configuration macro:
//   GIC_REG_LOCK_EN  when defined, CTRL.bit1 is a sticky LOCK bit that blocks
//                    writes to ENABLE and PRIO0..3 (those writes pulse
//                    o_addr_err). Undefined: CTRL.bit1 reads 0, no lock logic.
//
// Parameters:
//   NUM_IRQ  number of interrupt sources, 1..32
//   PRIO_W   priority field width (fields are packed on a 4-bit stride)
//
// Ports:
//   i_clk       single clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_addr      byte address
//   i_wr_en     write strobe
//   i_rd_en     read strobe
//   i_wdata     write data
//   o_rdata     registered read data, holds while i_rd_en is low
//   o_addr_err  one-cycle pulse after an unmapped (or locked) access
//   i_irq_in    level interrupt sources, a rising edge sets pending
//   o_irq_out   registered interrupt request to the core
// -----------------------------------------------------------------------------
module gic_reg_slave #(
   parameter int NUM_IRQ = 16,
   parameter int PRIO_W  = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [7:0]         i_addr,
   input  logic               i_wr_en,
   input  logic               i_rd_en,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_rdata,
   output logic               o_addr_err,
   input  logic [NUM_IRQ-1:0] i_irq_in,
   output logic               o_irq_out
);

   // Word indices (byte address >> 2)
   localparam logic [5:0] W_CTRL    = 6'd0;
   localparam logic [5:0] W_ENABLE  = 6'd1;
   localparam logic [5:0] W_PENDING = 6'd2;
   localparam logic [5:0] W_SETPEND = 6'd3;
   localparam logic [5:0] W_CLAIM   = 6'd4;
   localparam logic [5:0] W_PRIO0   = 6'd8;
   localparam logic [5:0] W_PRIO1   = 6'd9;
   localparam logic [5:0] W_PRIO2   = 6'd10;
   localparam logic [5:0] W_PRIO3   = 6'd11;

   // ---------------------------------------------------------------- state
   logic                r_ctrl_en;
   logic [NUM_IRQ-1:0]  r_enable;
   logic [NUM_IRQ-1:0]  r_pending;
   logic [NUM_IRQ-1:0]  r_irq_q;
   logic [PRIO_W-1:0]   r_prio [NUM_IRQ];
   logic [31:0]         r_rdata;
   logic                r_addr_err;
   logic                r_irq_out;

   // ---------------------------------------------------------------- wires
   logic [5:0]          w_word;
   logic                w_is_prio;
   logic                w_mapped;
   logic                w_lock;
   logic                w_lock_blk;
   logic                w_wr_ok;
   logic                w_err;
   logic [NUM_IRQ-1:0]  w_cand;
   logic                w_any_cand;
   logic [PRIO_W-1:0]   w_best_prio;
   logic [4:0]          w_best_id;
   logic [NUM_IRQ-1:0]  w_claim_mask;
   logic                w_claim;
   logic [NUM_IRQ-1:0]  w_set;
   logic [NUM_IRQ-1:0]  w_clr;
   logic [NUM_IRQ-1:0]  w_pend_nxt;
   logic [127:0]        w_prio_flat;
   logic [31:0]         w_rd_val;
   logic                w_unused;

   assign w_word    = i_addr[7:2];
   assign w_is_prio = (w_word >= W_PRIO0) && (w_word <= W_PRIO3);
   // Byte-lane bits are deliberately ignored (word access only)
   assign w_unused  = ^i_addr[1:0];

   // Address decode: which word indices exist in the map
   always_comb begin
      w_mapped = 1'b0;
      case (w_word)
         W_CTRL, W_ENABLE, W_PENDING, W_SETPEND, W_CLAIM,
         W_PRIO0, W_PRIO1, W_PRIO2, W_PRIO3: w_mapped = 1'b1;
         default:                            w_mapped = 1'b0;
      endcase
   end

`ifdef GIC_REG_LOCK_EN
   logic r_lock;

   // Sticky LOCK bit: set by writing 1 to CTRL.bit1, cleared only by reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lock <= 1'b0;
      end else if (i_wr_en && (w_word == W_CTRL)) begin
         r_lock <= r_lock | i_wdata[1];
      end
   end

   assign w_lock = r_lock;
`else
   assign w_lock = 1'b0;
`endif

   // A locked configuration write is dropped and reported like a bad address
   assign w_lock_blk = w_lock & i_wr_en & ((w_word == W_ENABLE) | w_is_prio);
   assign w_wr_ok    = i_wr_en & ~w_lock_blk;
   assign w_err      = ((i_wr_en | i_rd_en) & ~w_mapped) | w_lock_blk;

   // Candidate vector: pending, enabled and a non-zero priority
   always_comb begin
      w_cand = '0;
      for (int n = 0; n < NUM_IRQ; n++) begin
         w_cand[n] = r_pending[n] & r_enable[n] & (r_prio[n] != '0);
      end
   end

   assign w_any_cand = |w_cand;

   // Priority arbiter: strict '>' over ascending index keeps the lowest id on
   // a tie; the running best starts at 0 so any candidate beats it
   always_comb begin
      w_best_prio = '0;
      w_best_id   = 5'd0;
      for (int n = 0; n < NUM_IRQ; n++) begin
         w_best_id   = (w_cand[n] && (r_prio[n] > w_best_prio)) ? 5'(n)     : w_best_id;
         w_best_prio = (w_cand[n] && (r_prio[n] > w_best_prio)) ? r_prio[n] : w_best_prio;
      end
   end

   // One-hot mask of the arbitration winner
   always_comb begin
      w_claim_mask = '0;
      for (int n = 0; n < NUM_IRQ; n++) begin
         w_claim_mask[n] = (w_best_id == 5'(n));
      end
   end

   assign w_claim = i_rd_en & (w_word == W_CLAIM) & w_any_cand;

   // Pending update: set sources are OR-ed after clears so a set always wins
   always_comb begin
      w_set = i_irq_in & ~r_irq_q;
      if (i_wr_en && (w_word == W_SETPEND)) begin
         w_set = w_set | i_wdata[NUM_IRQ-1:0];
      end else begin
         w_set = w_set;
      end
      w_clr = '0;
      if (i_wr_en && (w_word == W_PENDING)) begin
         w_clr = i_wdata[NUM_IRQ-1:0];
      end else begin
         w_clr = '0;
      end
      if (w_claim) begin
         w_clr = w_clr | w_claim_mask;
      end else begin
         w_clr = w_clr;
      end
      w_pend_nxt = (r_pending & ~w_clr) | w_set;
   end

   // Flattened priority image of all four PRIO words, zero past NUM_IRQ
   for (genvar g = 0; g < 32; g++) begin : g_prio
      if (g < NUM_IRQ) begin : g_on
         assign w_prio_flat[4*g +: 4] = 4'(r_prio[g]);
      end else begin : g_off
         assign w_prio_flat[4*g +: 4] = 4'd0;
      end
   end

   // Read-data mux on the pre-edge register values
   always_comb begin
      w_rd_val = 32'd0;
      case (w_word)
         W_CTRL:    w_rd_val = {30'd0, w_lock, r_ctrl_en};
         W_ENABLE:  w_rd_val = 32'(r_enable);
         W_PENDING: w_rd_val = 32'(r_pending);
         W_SETPEND: w_rd_val = 32'd0;
         W_CLAIM:   w_rd_val = w_any_cand ? {1'b1, 26'd0, w_best_id} : 32'd0;
         W_PRIO0:   w_rd_val = w_prio_flat[31:0];
         W_PRIO1:   w_rd_val = w_prio_flat[63:32];
         W_PRIO2:   w_rd_val = w_prio_flat[95:64];
         W_PRIO3:   w_rd_val = w_prio_flat[127:96];
         default:   w_rd_val = 32'd0;
      endcase
   end

   // Control and enable registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ctrl_en <= 1'b0;
         r_enable  <= '0;
      end else begin
         if (w_wr_ok && (w_word == W_CTRL)) begin
            r_ctrl_en <= i_wdata[0];
         end
         if (w_wr_ok && (w_word == W_ENABLE)) begin
            r_enable <= i_wdata[NUM_IRQ-1:0];
         end
      end
   end

   // Priority fields: IRQ n lives in word PRIO0+n/8 at nibble n%8
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int n = 0; n < NUM_IRQ; n++) begin
            r_prio[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_IRQ; n++) begin
            if (w_wr_ok && (w_word == (W_PRIO0 + 6'(n / 8)))) begin
               r_prio[n] <= i_wdata[4*(n%8) +: PRIO_W];
            end
         end
      end
   end

   // Edge-detect history and pending register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_irq_q   <= '0;
         r_pending <= '0;
      end else begin
         r_irq_q   <= i_irq_in;
         r_pending <= w_pend_nxt;
      end
   end

   // Registered bus responses and interrupt request
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata    <= 32'd0;
         r_addr_err <= 1'b0;
         r_irq_out  <= 1'b0;
      end else begin
         if (i_rd_en) begin
            r_rdata <= w_rd_val;
         end
         r_addr_err <= w_err;
         r_irq_out  <= r_ctrl_en & w_any_cand;
      end
   end

   assign o_rdata    = r_rdata;
   assign o_addr_err = r_addr_err;
   assign o_irq_out  = r_irq_out;

endmodule

// File: tb/tb_gic_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_gic_reg_slave
//
// Self-checking bench for gic_reg_slave (NUM_IRQ=16). A transaction-level
// reference model holds the register file as plain arrays and predicts
// rdata / addr_err / irq_out every cycle; directed sequences add constant
// expectations for the documented scenarios, then a randomized phase runs.
// Define GIC_REG_LOCK_EN for both RTL and bench to exercise the LOCK bit.
// -----------------------------------------------------------------------------
module tb_gic_reg_slave;

   localparam int N = 16;

   logic        clk;
   logic        rst;
   logic [7:0]  addr;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        addr_err;
   logic [N-1:0] irq_in;
   logic        irq_out;

   gic_reg_slave #(.NUM_IRQ(N), .PRIO_W(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_addr     (addr),
      .i_wr_en    (wr_en),
      .i_rd_en    (rd_en),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .o_addr_err (addr_err),
      .i_irq_in   (irq_in),
      .o_irq_out  (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ----------------------------------------------------------- reference model
   logic         m_en;
   logic         m_lock;
   logic [N-1:0] m_enable;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_irqq;
   logic [3:0]   m_prio [N];
   logic [31:0]  e_rdata;
   logic         e_err;
   logic         e_irq;
   logic [N-1:0] cur_irq;

   // Highest priority level first, lowest index within a level
   function automatic int m_winner();
      for (int p = 15; p >= 1; p--) begin
         for (int n = 0; n < N; n++) begin
            if (m_pend[n] && m_enable[n] && (m_prio[n] == 4'(p))) return n;
         end
      end
      return -1;
   endfunction

   function automatic logic m_is_mapped(input logic [7:0] am);
      return (am == 8'h00) || (am == 8'h04) || (am == 8'h08) || (am == 8'h0C) ||
             (am == 8'h10) || (am == 8'h20) || (am == 8'h24) || (am == 8'h28) ||
             (am == 8'h2C);
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] am, input int w);
      logic [31:0] v;
      v = 32'd0;
      case (am)
         8'h00: v = {30'd0, m_lock, m_en};
         8'h04: v = {16'd0, m_enable};
         8'h08: v = {16'd0, m_pend};
         8'h10: v = (w >= 0) ? {1'b1, 26'd0, 5'(w)} : 32'd0;
         8'h20: for (int j = 0; j < 8; j++) v[4*j +: 4] = m_prio[j];
         8'h24: for (int j = 0; j < 8; j++) v[4*j +: 4] = m_prio[8+j];
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   // Advance the model by one clock with the given bus/irq inputs
   task automatic model_step(input logic wr, input logic rd, input logic [7:0] a,
                             input logic [31:0] wd, input logic [N-1:0] irq, input logic rs);
      logic [7:0]   am;
      int           w;
      logic         blk;
      logic [N-1:0] set, clr;
      if (rs) begin
         m_en = 1'b0; m_lock = 1'b0; m_enable = '0; m_pend = '0; m_irqq = '0;
         for (int n = 0; n < N; n++) m_prio[n] = 4'd0;
         e_rdata = 32'd0; e_err = 1'b0; e_irq = 1'b0;
         return;
      end
      am  = a & 8'hFC;
      w   = m_winner();
      blk = m_lock && wr && ((am == 8'h04) || ((am >= 8'h20) && (am <= 8'h2C)));
      e_err = ((wr || rd) && !m_is_mapped(am)) || blk;
      e_irq = m_en && (w >= 0);
      if (rd) e_rdata = m_read(am, w);
      set = irq & ~m_irqq;
      if (wr && am == 8'h0C) set = set | wd[N-1:0];
      clr = '0;
      if (wr && am == 8'h08) clr = wd[N-1:0];
      if (rd && am == 8'h10 && w >= 0) clr[w] = 1'b1;
      m_pend = (m_pend & ~clr) | set;
      if (wr && !blk) begin
         case (am)
            8'h00: begin
               m_en = wd[0];
`ifdef GIC_REG_LOCK_EN
               m_lock = m_lock | wd[1];
`endif
            end
            8'h04: m_enable = wd[N-1:0];
            8'h20: for (int j = 0; j < 8; j++) m_prio[j]   = wd[4*j +: 4];
            8'h24: for (int j = 0; j < 8; j++) m_prio[8+j] = wd[4*j +: 4];
            default: ;
         endcase
      end
      m_irqq = irq;
   endtask

   // One bus cycle: drive, step the model, clock, then check all outputs
   task automatic cyc(input logic wr, input logic rd, input logic [7:0] a,
                      input logic [31:0] wd, input logic rs);
      wr_en = wr; rd_en = rd; addr = a; wdata = wd; rst = rs; irq_in = cur_irq;
      model_step(wr, rd, a, wd, cur_irq, rs);
      @(posedge clk);
      #1;
      chk("rdata", rdata, e_rdata);
      chk("addr_err", 32'(addr_err), 32'(e_err));
      chk("irq_out", 32'(irq_out), 32'(e_irq));
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic do_wr(input logic [7:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b0, a, d, 1'b0);
   endtask

   task automatic do_rd(input logic [7:0] a);
      cyc(1'b0, 1'b1, a, 32'd0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
   endtask

   logic [7:0] map_tab [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                               8'h20, 8'h24, 8'h28, 8'h2C};
   logic [7:0] addr_tab [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20,
                                 8'h24, 8'h28, 8'h2C, 8'h14, 8'h40, 8'hFC};

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 8'h00; wdata = 32'd0;
      irq_in = '0; cur_irq = '0;
      @(negedge clk);

      // Reset and empty register map
      cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, 8'h04, 32'hFFFF_FFFF, 1'b1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", 32'(addr_err), 32'd0);
      chk("rst_irq", 32'(irq_out), 32'd0);
      for (int i = 0; i < 9; i++) begin
         do_rd(map_tab[i]);
         chk("rst_map_rd", rdata, 32'd0);
         chk("rst_map_err", 32'(addr_err), 32'd0);
      end
      do_rd(8'h40);
      chk("unmap_err", 32'(addr_err), 32'd1);
      chk("unmap_rdata", rdata, 32'd0);
      idle();
      chk("unmap_err_once", 32'(addr_err), 32'd0);

      // Basic priority flow
      do_wr(8'h04, 32'h0000_0005);
      do_wr(8'h20, 32'h0000_0302);
      do_wr(8'h00, 32'h0000_0001);
      cur_irq = 16'h0005;
      idle();
      chk("irq_lat1", 32'(irq_out), 32'd0);
      cur_irq = 16'h0000;
      idle();
      chk("irq_lat2", 32'(irq_out), 32'd1);
      do_rd(8'h10);
      chk("claim1", rdata, 32'h8000_0002);
      do_rd(8'h10);
      chk("claim2", rdata, 32'h8000_0000);
      do_rd(8'h10);
      chk("claim3", rdata, 32'h0000_0000);
      chk("irq_drop", 32'(irq_out), 32'd0);

      // Tie-break on equal priority
      do_wr(8'h20, 32'h0070_7000);
      do_wr(8'h04, 32'h0000_0028);
      do_wr(8'h0C, 32'h0000_0028);
      do_rd(8'h10);
      chk("tie_first", rdata, 32'h8000_0003);
      do_rd(8'h10);
      chk("tie_second", rdata, 32'h8000_0005);

      // Same-cycle conflicts
      cur_irq = 16'h0002;
      do_wr(8'h08, 32'h0000_0002);
      do_rd(8'h08);
      chk("set_wins", rdata, 32'h0000_0002);
      cyc(1'b1, 1'b1, 8'h04, 32'h0000_1234, 1'b0);
      chk("wr_rd_old", rdata, 32'h0000_0028);
      do_rd(8'h04);
      chk("wr_rd_new", rdata, 32'h0000_1234);
      cur_irq = 16'h0000;
      do_wr(8'h08, 32'h0000_0002);

      // Gating by global enable and zero priority
      do_wr(8'h00, 32'h0000_0001);
      do_wr(8'h04, 32'h0000_0001);
      do_wr(8'h20, 32'h0000_0000);
      do_wr(8'h0C, 32'h0000_0001);
      idle();
      idle();
      chk("prio0_noirq", 32'(irq_out), 32'd0);
      do_wr(8'h00, 32'h0000_0000);
      do_wr(8'h20, 32'h0000_0001);
      idle();
      chk("ctrl0_noirq", 32'(irq_out), 32'd0);
      do_wr(8'h00, 32'h0000_0001);
      chk("ctrl1_same", 32'(irq_out), 32'd0);
      idle();
      chk("ctrl1_next", 32'(irq_out), 32'd1);

`ifdef GIC_REG_LOCK_EN
      do_wr(8'h00, 32'h0000_0003);
      do_wr(8'h04, 32'h0000_FFFF);
      chk("lock_err", 32'(addr_err), 32'd1);
      do_rd(8'h04);
      chk("lock_enable", rdata, 32'h0000_0001);
      do_wr(8'h00, 32'h0000_0001);
      do_rd(8'h00);
      chk("lock_sticky", rdata, 32'h0000_0003);
      cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
      do_rd(8'h00);
      chk("lock_rst", rdata, 32'h0000_0000);
`endif

      // Randomized traffic against the model
      cyc(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
      for (int i = 0; i < 800; i++) begin
         logic       r_wr, r_rd, r_rs;
         logic [7:0] r_a;
         r_wr = ($urandom_range(0, 2) == 0);
         r_rd = ($urandom_range(0, 1) == 0);
         r_rs = ($urandom_range(0, 149) == 0);
         r_a  = addr_tab[$urandom_range(0, 11)] | 8'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) cur_irq = 16'($urandom());
         cyc(r_wr, r_rd, r_a, $urandom(), r_rs);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
